serial_full_adder: RTL

Bit-serial WIDTH-bit adder built around one instance of the team's decoder-based 1-bit full adder cell (FA_by_DECODER). It consumes that cell's sum/carry outputs one bit per clock, feeds the carry back through a register, and assembles the result LSB-first. It sits downstream of the full-adder cell and trades latency for area in the arithmetic datapath. A start/busy/done handshake frames each operation.

---
 rtl/serial_full_adder_if.sv | 24 ++
 rtl/serial_full_adder.sv | 100 ++++++++++
 2 files changed

// File: rtl/serial_full_adder_if.sv
// Operand/result bundle for the bit-serial adder: request side (master)
// drives start and operands, adder side (slave) returns status and result.
interface serial_full_adder_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_full_adder.sv
// Bit-serial WIDTH-bit adder: one decoder-based full-adder cell evaluated once
// per clock, carry fed back through a register, result assembled LSB-first.
module serial_full_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_full_adder_if.slave  bus
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    // Minterm masks of the 3-to-8 decoder feeding the full-adder cell
    localparam logic [7:0] SUM_MASK   = 8'b1001_0110;
    localparam logic [7:0] CARRY_MASK = 8'b1110_1000;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_sh, a_nx;
    logic [WIDTH-1:0] b_sh, b_nx;
    logic [WIDTH-1:0] r_sh, r_nx;
    logic             c_reg, c_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [WIDTH-1:0] sum_q, sum_nx;
    logic             cout_q, cout_nx;

    logic [7:0]       dec;
    logic             fa_sum;
    logic             fa_carry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            r_sh   <= '0;
            c_reg  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            state  <= state_nx;
            a_sh   <= a_nx;
            b_sh   <= b_nx;
            r_sh   <= r_nx;
            c_reg  <= c_nx;
            cnt    <= cnt_nx;
            sum_q  <= sum_nx;
            cout_q <= cout_nx;
        end
    end

    always_comb begin
        dec      = 8'd1 << {a_sh[0], b_sh[0], c_reg};
        fa_sum   = |(dec & SUM_MASK);
        fa_carry = |(dec & CARRY_MASK);

        state_nx = state;
        a_nx     = a_sh;
        b_nx     = b_sh;
        r_nx     = r_sh;
        c_nx     = c_reg;
        cnt_nx   = cnt;
        sum_nx   = sum_q;
        cout_nx  = cout_q;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    a_nx     = bus.a;
                    b_nx     = bus.b;
                    c_nx     = bus.cin;
                    cnt_nx   = '0;
                    state_nx = RUN;
                end
            end
            RUN: begin
                a_nx   = a_sh >> 1;
                b_nx   = b_sh >> 1;
                r_nx   = (r_sh >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
                c_nx   = fa_carry;
                cnt_nx = cnt + CW'(1);
                // Publish only the fully shifted result so partial sums stay hidden
                if (cnt == LAST) begin
                    sum_nx   = r_nx;
                    cout_nx  = fa_carry;
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule
